// File: rtl/fp_divider_32_if.sv
// Start/busy/done handshake bundle for the sequential fp32 divider.
// master drives the request, slave is the divider.
interface fp_divider_32_seq_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [3:0]  flags;

   modport master (
      output start, a, b,
      input  busy, done, result, flags
   );

   modport slave (
      input  start, a, b,
      output busy, done, result, flags
   );
endinterface

// File: rtl/fp_divider_32_seq.sv
// Sequential fp32 divider: radix-2 restoring, 1 bit/clk, RNE, FTZ.
// Define FPDIV_EARLY_OUT_EN to skip CALC for zero/inf/NaN operands.
module fp_divider_32_seq (
   input logic               clk,
   input logic               rst_n,
   fp_divider_32_seq_if.slave io
);

`ifdef FPDIV_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, ROUND} state_e;

   state_e state_q, state_d;

   logic [4:0]        cnt_q, cnt_d;
   logic [25:0]       rem_q, rem_d;
   logic [25:0]       quo_q, quo_d;
   logic [23:0]       mb_q, mb_d;
   logic signed [9:0] exp_q, exp_d;
   logic              sign_q, sign_d;
   logic              spec_q, spec_d;
   logic [31:0]       sres_q, sres_d;
   logic [3:0]        sflg_q, sflg_d;
   logic [31:0]       result_q, result_d;
   logic [3:0]        flags_q, flags_d;
   logic              done_q, done_d;

   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        za, ia, na, zb, ib, nb;
   logic        sgn_in;
   logic        cap_spec;
   logic [31:0] cap_res;
   logic [3:0]  cap_flg;
   logic [23:0] ma, mb;
   logic        lt;
   logic        accept;

   assign ea     = io.a[30:23];
   assign eb     = io.b[30:23];
   assign fa     = io.a[22:0];
   assign fb     = io.b[22:0];
   assign za     = (ea == 8'd0);
   assign zb     = (eb == 8'd0);
   assign ia     = (ea == 8'hFF) && (fa == 23'd0);
   assign ib     = (eb == 8'hFF) && (fb == 23'd0);
   assign na     = (ea == 8'hFF) && (fa != 23'd0);
   assign nb     = (eb == 8'hFF) && (fb != 23'd0);
   assign sgn_in = io.a[31] ^ io.b[31];
   assign ma     = {1'b1, fa};
   assign mb     = {1'b1, fb};
   assign lt     = (ma < mb);
   assign accept = (state_q == IDLE) && io.start;

   // Priority order matters: NaN/0-0/inf-inf beat inf/x beat x/0.
   always_comb begin
      cap_spec = za | ia | na | zb | ib | nb;
      cap_res  = 32'd0;
      cap_flg  = 4'd0;
      if (na | nb | (za & zb) | (ia & ib)) begin
         cap_res = 32'h7FC0_0000;
         cap_flg = 4'b1000;
      end else if (ia) begin
         cap_res = {sgn_in, 8'hFF, 23'd0};
      end else if (zb) begin
         cap_res = {sgn_in, 8'hFF, 23'd0};
         cap_flg = 4'b0100;
      end else if (za | ib) begin
         cap_res = {sgn_in, 31'd0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (io.start) begin
               state_d = (EARLY_OUT && cap_spec) ? ROUND : CALC;
            end
         end
         CALC: begin
            if (cnt_q == 5'd25) state_d = ROUND;
         end
         ROUND:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic        ge;
   logic [25:0] rem_sub;

   always_comb begin
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      mb_d    = mb_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      spec_d  = spec_q;
      sres_d  = sres_q;
      sflg_d  = sflg_q;
      ge      = (rem_q >= {2'b00, mb_q});
      rem_sub = ge ? (rem_q - {2'b00, mb_q}) : rem_q;
      if (accept) begin
         cnt_d  = 5'd0;
         quo_d  = 26'd0;
         mb_d   = mb;
         sign_d = sgn_in;
         spec_d = cap_spec;
         sres_d = cap_res;
         sflg_d = cap_flg;
         rem_d  = lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
         exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb})
                  + (lt ? 10'sd126 : 10'sd127);
      end else if (state_q == CALC) begin
         cnt_d = cnt_q + 5'd1;
         rem_d = {rem_sub[24:0], 1'b0};
         quo_d = {quo_q[24:0], ge};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 5'd0;
         rem_q  <= 26'd0;
         quo_q  <= 26'd0;
         mb_q   <= 24'd0;
         exp_q  <= 10'sd0;
         sign_q <= 1'b0;
         spec_q <= 1'b0;
         sres_q <= 32'd0;
         sflg_q <= 4'd0;
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         mb_q   <= mb_d;
         exp_q  <= exp_d;
         sign_q <= sign_d;
         spec_q <= spec_d;
         sres_q <= sres_d;
         sflg_q <= sflg_d;
      end
   end

   logic              inc;
   logic [24:0]       mant;
   logic signed [9:0] exp_r;
   logic [31:0]       nres;
   logic [3:0]        nflg;

   // A carry out of the mantissa leaves mant[23]=0 and frac=0 (1.0).
   always_comb begin
      inc   = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
      mant  = {1'b0, quo_q[25:2]} + {24'd0, inc};
      exp_r = exp_q + $signed({9'd0, mant[24]});
      nres  = {sign_q, exp_r[7:0], mant[23] ? mant[22:0] : 23'd0};
      nflg  = 4'd0;
      if (exp_r >= 10'sd255) begin
         nres = {sign_q, 8'hFF, 23'd0};
         nflg = 4'b0010;
      end else if (exp_r <= 10'sd0) begin
         nres = {sign_q, 31'd0};
         nflg = 4'b0001;
      end
   end

   always_comb begin
      done_d   = (state_q == ROUND);
      result_d = result_q;
      flags_d  = flags_q;
      if (done_d) begin
         result_d = spec_q ? sres_q : nres;
         flags_d  = spec_q ? sflg_q : nflg;
      end
      io.busy   = (state_q != IDLE);
      io.done   = done_q;
      io.result = result_q;
      io.flags  = flags_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q   <= 1'b0;
         result_q <= 32'd0;
         flags_q  <= 4'd0;
      end else begin
         done_q   <= done_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_divider_32_seq.sv
// Directed scoreboard bench for fp_divider_32_seq.
// Expected results queued at issue, checked when done pulses.
module tb_fp_divider_32_seq;

`ifdef FPDIV_EARLY_OUT_EN
   localparam int SPL = 1;
`else
   localparam int SPL = 27;
`endif

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fp_divider_32_seq_if ifc ();

   fp_divider_32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifc.slave)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          t0;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ndone = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && ifc.done === 1'b1) begin
         ndone++;
         chk("done_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_res"}, ifc.result, e.res);
            chk({e.tag, "_flg"}, ifc.flags, e.flg);
            chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
            chk({e.tag, "_busy_done"}, ifc.busy, 0);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] flg,
                        input int lat, input string tag);
      @(negedge clk);
      ifc.a     = a;
      ifc.b     = b;
      ifc.start = 1'b1;
      sb.push_back('{res: res, flg: flg, t0: cyc + 1, lat: lat, tag: tag});
      @(negedge clk);
      ifc.start = 1'b0;
      chk({tag, "_busy"}, ifc.busy, 1);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain"}, sb.size(), 0);
   endtask

   initial begin
      int d0;
      int n;
      ifc.start = 1'b0;
      ifc.a     = 32'd0;
      ifc.b     = 32'd0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_result", ifc.result, 0);
      chk("rst_flags", ifc.flags, 0);
      rst_n = 1'b1;

      // 6/2 with busy held through the CALC window
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, "six_by_two");
      repeat (25) @(negedge clk);
      chk("six_by_two_busy_e26", ifc.busy, 1);
      drain("six_by_two");

      // back-to-back with start held in the done cycle
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27, "one_third");
      n = 0;
      while (ifc.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_wait", ifc.done, 1);
      ifc.a     = 32'hC0400000;
      ifc.b     = 32'h40000000;
      ifc.start = 1'b1;
      sb.push_back('{res: 32'hBFC00000, flg: 4'b0000, t0: cyc + 1, lat: 27,
                     tag: "neg_three_halves"});
      @(negedge clk);
      ifc.start = 1'b0;
      chk("b2b_accept", ifc.busy, 1);
      drain("b2b");

      // special operands
      issue(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, SPL, "div_zero");
      drain("div_zero");
      issue(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, SPL, "zero_zero");
      drain("zero_zero");
      issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, SPL, "nan_in");
      drain("nan_in");
      issue(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, SPL, "inf_fin");
      drain("inf_fin");
      issue(32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, SPL, "fin_inf");
      drain("fin_inf");

      // exponent range
      issue(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 27, "ovf");
      drain("ovf");
      issue(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27, "unf_pos");
      drain("unf_pos");
      issue(32'h80800000, 32'h40000000, 32'h80000000, 4'b0001, 27, "unf_neg");
      drain("unf_neg");

      // start during busy must be ignored
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27, "ign_first");
      repeat (4) @(negedge clk);
      ifc.a     = 32'h40C00000;
      ifc.b     = 32'h40000000;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      drain("ign_first");
      d0 = ndone;
      repeat (40) @(negedge clk);
      chk("ign_no_second", ndone - d0, 0);

      // reset mid-operation aborts silently
      @(negedge clk);
      ifc.a     = 32'h40C00000;
      ifc.b     = 32'h40000000;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", ifc.busy, 0);
      chk("mid_rst_result", ifc.result, 0);
      chk("mid_rst_flags", ifc.flags, 0);
      chk("mid_rst_done", ifc.done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = ndone;
      repeat (40) @(negedge clk);
      chk("mid_rst_no_done", ndone - d0, 0);
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, "post_rst");
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
